upa2_mc: RTL and testbench

Multi-channel, pipelined successor to the single-channel UPA2 coefficient updater of the G.726 ADPCM adaptive predictor. It computes the second-order pole coefficient update A2T per channel and applies the optional LIMC clamp to produce A2P. A2 state for every channel is held in an internal bank, so the surrounding datapath supplies only per-sample sign bits and A1. It sits between the time-multiplexed predictor front end and the channel scheduler, with valid/ready handshakes on input and output.

---
 rtl/upa2_mc.sv | 135 +++++++++++++
 tb/tb_upa2_mc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upa2_mc.sv
// Multi-channel pipelined G.726 UPA2 pole-coefficient updater with a per-channel A2 bank.
// Stage 1 registers the request, uga2 and the A2 read; stage 2 holds the result and writes A2P back.
module upa2_mc #(
    parameter int CH       = 4,
    parameter int CHW      = 2,
    parameter bit LIMIT_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic           PK0,
    input  logic           PK1,
    input  logic           PK2,
    input  logic           SIGPK,
    input  logic [15:0]    A1,
    input  logic           load_valid,
    input  logic [CHW-1:0] load_ch,
    input  logic [15:0]    load_a2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [15:0]    A2T,
    output logic [15:0]    A2P
);

    logic [15:0]    bank [CH];
    logic           s1_valid;
    logic [CHW-1:0] s1_ch;
    logic [15:0]    s1_uga2;
    logic [15:0]    s1_a2;

    logic           s1_advance;
    logic           wb_en;
    logic           accept;
    logic [15:0]    uga2_in;
    logic [15:0]    ula2;
    logic [15:0]    a2t_next;
    logic [15:0]    a2p_next;
    logic [15:0]    cap_a2;

    function automatic logic [15:0] calc_uga2(
        input logic        pk0,
        input logic        pk1,
        input logic        pk2,
        input logic        sigpk,
        input logic [15:0] a1
    );
        logic        pks1;
        logic        pks2;
        logic [16:0] uga2a;
        logic [16:0] fa1;
        logic [16:0] fa;
        logic [16:0] uga2b;
        pks1  = pk0 ^ pk1;
        pks2  = pk0 ^ pk2;
        uga2a = pks2 ? 17'd114688 : 17'd16384;
        if (!a1[15])
            fa1 = (a1 > 16'd8191) ? 17'd32764 : {a1[14:0], 2'b00};
        else
            fa1 = (a1 >= 16'd57345) ? {a1[14:0], 2'b00} : 17'd98308;
        fa    = pks1 ? fa1 : (17'd0 - fa1);
        uga2b = uga2a + fa;
        if (sigpk)
            calc_uga2 = 16'd0;
        else if (uga2b[16])
            calc_uga2 = 16'(uga2b >> 7) + 16'd64512;
        else
            calc_uga2 = 16'(uga2b >> 7);
    endfunction

    assign s1_advance = !out_valid || out_ready;
    assign wb_en      = s1_valid && s1_advance;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;

    always_comb begin
        uga2_in  = calc_uga2(PK0, PK1, PK2, SIGPK, A1);
        ula2     = s1_a2[15] ? (16'd0 - (16'(s1_a2 >> 7) + 16'd65024))
                             : (16'd0 - 16'(s1_a2 >> 7));
        a2t_next = s1_a2 + s1_uga2 + ula2;
        a2p_next = a2t_next;
        if (LIMIT_EN && ($signed(a2t_next) > 16'sd12288))
            a2p_next = 16'h3000;
        else if (LIMIT_EN && ($signed(a2t_next) < -16'sd12288))
            a2p_next = 16'hD000;
    end

    // A same-edge load beats a same-edge writeback, which beats the stale bank entry.
    always_comb begin
        cap_a2 = bank[in_ch];
        if (wb_en && (s1_ch == in_ch))
            cap_a2 = a2p_next;
        if (load_valid && (load_ch == in_ch))
            cap_a2 = load_a2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++)
                bank[i] <= '0;
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_uga2   <= '0;
            s1_a2     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            A2T       <= '0;
            A2P       <= '0;
        end else begin
            if (wb_en)
                bank[s1_ch] <= a2p_next;
            if (load_valid)
                bank[load_ch] <= load_a2;
            if (s1_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ch <= s1_ch;
                    A2T    <= a2t_next;
                    A2P    <= a2p_next;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_ch    <= in_ch;
                s1_uga2  <= uga2_in;
                s1_a2    <= cap_a2;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_upa2_mc.sv
// Self-checking bench for upa2_mc: limited and unlimited instances share stimulus and are
// compared every cycle against a transaction-level model of the bank and the two-deep pipe.
module tb_upa2_mc;

    localparam int CH  = 4;
    localparam int CHW = 2;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic           PK0, PK1, PK2, SIGPK;
    logic [15:0]    A1;
    logic           load_valid;
    logic [CHW-1:0] load_ch;
    logic [15:0]    load_a2;
    logic           out_ready;

    logic           in_ready,  in_ready_nl;
    logic           out_valid, out_valid_nl;
    logic [CHW-1:0] out_ch,    out_ch_nl;
    logic [15:0]    a2t,       a2t_nl;
    logic [15:0]    a2p,       a2p_nl;

    int compared   = 0;
    int mismatched = 0;

    // Model: bank per instance (0 = limited, 1 = unlimited), one pending request, one output slot.
    int mb [2][CH];
    bit m_s1v;
    int m_s1ch;
    int m_s1t [2];
    int m_s1p [2];
    bit m_ov;
    int m_och;
    int m_ot [2];
    int m_op [2];
    bit last_acc;

    upa2_mc #(.CH(CH), .CHW(CHW), .LIMIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .PK0(PK0), .PK1(PK1), .PK2(PK2), .SIGPK(SIGPK), .A1(A1),
        .load_valid(load_valid), .load_ch(load_ch), .load_a2(load_a2),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .A2T(a2t), .A2P(a2p)
    );

    upa2_mc #(.CH(CH), .CHW(CHW), .LIMIT_EN(1'b0)) dut_nl (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nl), .in_ch(in_ch),
        .PK0(PK0), .PK1(PK1), .PK2(PK2), .SIGPK(SIGPK), .A1(A1),
        .load_valid(load_valid), .load_ch(load_ch), .load_a2(load_a2),
        .out_valid(out_valid_nl), .out_ready(out_ready), .out_ch(out_ch_nl), .A2T(a2t_nl), .A2P(a2p_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_a2t(int pk0, int pk1, int pk2, int sig, int a1, int a2);
        int pks1, pks2, uga2a, fa1, fa, uga2b, uga2, ula2;
        pks1  = pk0 ^ pk1;
        pks2  = pk0 ^ pk2;
        uga2a = pks2 ? 114688 : 16384;
        if (a1 < 32768)
            fa1 = ((a1 < 8191) ? a1 : 8191) * 4;
        else
            fa1 = (a1 >= 57345) ? (a1 * 4) % 131072 : 24577 * 4;
        fa    = pks1 ? fa1 : (131072 - fa1) % 131072;
        uga2b = (uga2a + fa) % 131072;
        if (sig != 0)
            uga2 = 0;
        else
            uga2 = (uga2b >= 65536) ? uga2b / 128 + 64512 : uga2b / 128;
        if (a2 >= 32768)
            ula2 = (65536 - (a2 / 128 + 65024)) % 65536;
        else
            ula2 = (65536 - a2 / 128) % 65536;
        return (a2 + (uga2 + ula2) % 65536) % 65536;
    endfunction

    function automatic int ref_clamp(int t);
        int s;
        s = (t >= 32768) ? t - 65536 : t;
        if (s > 12288)  return 12288;
        if (s < -12288) return 53248;
        return t;
    endfunction

    function automatic logic [15:0] rand_a1();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 8191));
            1:       return 16'($urandom_range(8192, 32767));
            2:       return 16'($urandom_range(32768, 57344));
            default: return 16'($urandom_range(57345, 65535));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) mb[k][c] = 0;
            m_s1t[k] = 0; m_s1p[k] = 0; m_ot[k] = 0; m_op[k] = 0;
        end
        m_s1v = 1'b0; m_s1ch = 0; m_ov = 1'b0; m_och = 0; last_acc = 1'b0;
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit drain, wb, acc;
        int a2, ich, lch;
        int nt [2];
        int np [2];
        ich   = int'(in_ch);
        lch   = int'(load_ch);
        drain = !m_ov || out_ready;
        wb    = m_s1v && drain;
        acc   = in_valid && (!m_s1v || drain);
        for (int k = 0; k < 2; k++) begin
            nt[k] = 0;
            np[k] = 0;
            if (acc) begin
                if (load_valid && lch == ich)   a2 = int'(load_a2);
                else if (wb && m_s1ch == ich)   a2 = m_s1p[k];
                else                            a2 = mb[k][ich];
                nt[k] = ref_a2t(int'(PK0), int'(PK1), int'(PK2), int'(SIGPK), int'(A1), a2);
                np[k] = (k == 0) ? ref_clamp(nt[k]) : nt[k];
            end
            if (wb)         mb[k][m_s1ch] = m_s1p[k];
            if (load_valid) mb[k][lch]    = int'(load_a2);
        end
        if (drain) begin
            m_ov = m_s1v;
            if (m_s1v) begin
                m_och = m_s1ch;
                for (int k = 0; k < 2; k++) begin
                    m_ot[k] = m_s1t[k];
                    m_op[k] = m_s1p[k];
                end
            end
        end
        if (acc) begin
            m_s1v  = 1'b1;
            m_s1ch = ich;
            for (int k = 0; k < 2; k++) begin
                m_s1t[k] = nt[k];
                m_s1p[k] = np[k];
            end
        end else if (drain) begin
            m_s1v = 1'b0;
        end
        last_acc = acc;
    endtask

    task automatic checkOutput();
        bit exp_ready;
        exp_ready = !m_s1v || !m_ov || out_ready;
        check("in_ready", in_ready, exp_ready);
        check("in_ready_nl", in_ready_nl, exp_ready);
        check("out_valid", out_valid, m_ov);
        check("out_valid_nl", out_valid_nl, m_ov);
        if (m_ov) begin
            check("out_ch", out_ch, m_och);
            check("A2T", a2t, m_ot[0]);
            check("A2P", a2p, m_op[0]);
            check("out_ch_nl", out_ch_nl, m_och);
            check("A2T_nl", a2t_nl, m_ot[1]);
            check("A2P_nl", a2p_nl, m_op[1]);
        end
    endtask

    task automatic tick();
        #1;
        checkOutput();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input bit p0, input bit p1, input bit p2,
                           input bit sg, input logic [15:0] a1v);
        in_ch = CHW'(ch);
        PK0 = p0; PK1 = p1; PK2 = p2; SIGPK = sg; A1 = a1v;
    endtask

    // Holds a request until the handshake completes, bounded to 20 cycles.
    task automatic applyStimulus(input int ch, input bit p0, input bit p1, input bit p2,
                                 input bit sg, input logic [15:0] a1v);
        int waited;
        set_req(ch, p0, p1, p2, sg, a1v);
        in_valid = 1'b1;
        waited   = 0;
        do begin
            tick();
            waited++;
        end while (!last_acc && waited < 20);
        if (!last_acc) begin
            compared++;
            mismatched++;
            $error("FAIL accept_timeout observed=0 expected=1 ch=%0d", ch);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        load_valid = 1'b0;
        model_reset();
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_valid_nl", out_valid_nl, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int i;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        load_valid = 1'b0; load_ch = '0; load_a2 = '0;
        set_req(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ch", out_ch, 0);
        check("rst_A2T", a2t, 16'h0000);
        check("rst_A2P", a2p, 16'h0000);
        reset = 1'b0;
        $display("[TB] reset released");

        applyStimulus(0, 0, 0, 0, 0, 16'h0000);
        tick();
        check("ch0_first_A2T", a2t, 16'h0080);
        check("ch0_first_A2P", a2p, 16'h0080);
        check("ch0_first_ch", out_ch, 0);

        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        check("b2b_first_A2T", a2t, 16'h0080);
        tick();
        check("b2b_fwd_A2T", a2t, 16'h00FF);

        applyStimulus(2, 1, 1, 0, 0, 16'h0000);
        tick();
        check("ch2_neg_A2T", a2t, 16'hFF80);
        applyStimulus(3, 1, 1, 0, 1, 16'h0000);
        tick();
        check("ch3_sigpk_A2T", a2t, 16'h0000);

        load_valid = 1'b1; load_ch = 2'd0; load_a2 = 16'h3000;
        tick();
        load_valid = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 16'h0000);
        tick();
        check("clamp_A2T", a2t, 16'h3020);
        check("clamp_A2P", a2p, 16'h3000);
        check("noclamp_A2P", a2p_nl, 16'h3020);

        $display("[TB] stall with three offered requests");
        out_ready = 1'b0;
        i = 0;
        for (int n = 0; n < 4; n++) begin
            set_req(i, i[0], 1'b0, 1'b1, 1'b0, rand_a1());
            in_valid = 1'b1;
            tick();
            if (last_acc) i++;
        end
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        applyStimulus(i, 1, 0, 1, 0, rand_a1());
        for (int n = 0; n < 3; n++) tick();

        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        load_valid = 1'b1; load_ch = 2'd1; load_a2 = 16'h1000;
        tick();
        load_valid = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        tick();
        check("collision_A2T", a2t, 16'h1060);

        applyStimulus(2, 1, 0, 0, 0, rand_a1());
        applyStimulus(3, 0, 1, 1, 0, rand_a1());
        do_reset();
        applyStimulus(0, 0, 0, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        check("post_reset_ch0", a2t, 16'h0080);
        applyStimulus(2, 0, 0, 0, 0, 16'h0000);
        check("post_reset_ch1", a2t, 16'h0080);
        applyStimulus(3, 0, 0, 0, 0, 16'h0000);
        check("post_reset_ch2", a2t, 16'h0080);
        tick();
        check("post_reset_ch3", a2t, 16'h0080);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            set_req($urandom_range(0, CH - 1), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0), rand_a1());
            out_ready  = ($urandom_range(0, 3) != 0);
            load_valid = ($urandom_range(0, 9) == 0);
            load_ch    = CHW'($urandom_range(0, CH - 1));
            case ($urandom_range(0, 3))
                0:       load_a2 = 16'(12288 - 64 + $urandom_range(0, 128));
                1:       load_a2 = 16'(53248 - 64 + $urandom_range(0, 128));
                default: load_a2 = 16'($urandom);
            endcase
            tick();
        end
        in_valid = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
